// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory.
// Grants one access at a time and returns done plus read data.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int RR         = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_out,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE
  } state_t;

  state_t state, state_nx;

  logic                  last, last_nx;
  logic                  op, op_nx;
  logic                  cur, cur_nx;
  logic                  win;
  logic                  gnt0_nx, gnt1_nx;
  logic                  done0_nx, done1_nx;
  logic                  mem_we_nx, busy_nx;
  logic [ADDR_WIDTH-1:0] mem_addr_nx;
  logic [DATA_WIDTH-1:0] mem_data_nx;
  logic [DATA_WIDTH-1:0] rdata_nx;

  // Under contention the port that did not win last time goes next.
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      (req0 & req1):  win = (RR != 0) ? ~last : 1'b0;
      (req0 & ~req1): win = 1'b0;
      (~req0 & req1): win = 1'b1;
      default:        win = 1'b0;
    endcase
  end

  always_comb begin
    state_nx    = state;
    last_nx     = last;
    op_nx       = op;
    cur_nx      = cur;
    gnt0_nx     = 1'b0;
    gnt1_nx     = 1'b0;
    done0_nx    = 1'b0;
    done1_nx    = 1'b0;
    mem_we_nx   = 1'b0;
    mem_addr_nx = mem_addr;
    mem_data_nx = mem_data;
    rdata_nx    = rdata;
    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          state_nx    = ACCESS;
          cur_nx      = win;
          last_nx     = win;
          op_nx       = win ? we1 : we0;
          mem_we_nx   = win ? we1 : we0;
          mem_addr_nx = win ? addr1 : addr0;
          mem_data_nx = win ? wdata1 : wdata0;
          gnt0_nx     = ~win;
          gnt1_nx     = win;
        end
      end
      ACCESS: begin
        state_nx = CAPTURE;
      end
      CAPTURE: begin
        state_nx = IDLE;
        if (!op) rdata_nx = mem_out;
        done0_nx = ~cur;
        done1_nx = cur;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      op       <= 1'b0;
      cur      <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      mem_we   <= 1'b0;
      busy     <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      rdata    <= '0;
    end else begin
      state    <= state_nx;
      last     <= last_nx;
      op       <= op_nx;
      cur      <= cur_nx;
      gnt0     <= gnt0_nx;
      gnt1     <= gnt1_nx;
      done0    <= done0_nx;
      done1    <= done1_nx;
      mem_we   <= mem_we_nx;
      busy     <= busy_nx;
      mem_addr <= mem_addr_nx;
      mem_data <= mem_data_nx;
      rdata    <= rdata_nx;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [5:0]  addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;

  logic        a_gnt0, a_gnt1, a_done0, a_done1, a_we, a_busy;
  logic [15:0] a_rdata, a_data, a_mout;
  logic [5:0]  a_addr;
  logic        f_gnt0, f_gnt1, f_done0, f_done1, f_we, f_busy;
  logic [15:0] f_rdata, f_data, f_mout;
  logic [5:0]  f_addr;

  logic        pl_en = 1'b0;
  logic [5:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;
  logic [15:0] mem_a [64];
  logic [15:0] mem_f [64];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .RR(1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(a_gnt0), .gnt1(a_gnt1),
    .done0(a_done0), .done1(a_done1),
    .rdata(a_rdata), .mem_we(a_we),
    .mem_addr(a_addr), .mem_data(a_data),
    .mem_out(a_mout), .busy(a_busy)
  );

  mem_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .RR(0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(f_gnt0), .gnt1(f_gnt1),
    .done0(f_done0), .done1(f_done1),
    .rdata(f_rdata), .mem_we(f_we),
    .mem_addr(f_addr), .mem_data(f_data),
    .mem_out(f_mout), .busy(f_busy)
  );

  always @(posedge clk) begin
    if (pl_en) mem_a[pl_addr] <= pl_data;
    else if (a_we) mem_a[a_addr] <= a_data;
    a_mout <= mem_a[a_addr];
  end

  always @(posedge clk) begin
    if (pl_en) mem_f[pl_addr] <= pl_data;
    else if (f_we) mem_f[f_addr] <= f_data;
    f_mout <= mem_f[f_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [5:0] a, input logic [15:0] d);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++;
    if ({a_gnt0, a_gnt1, a_done0, a_done1, a_we, a_busy} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b exp=000000",
               {a_gnt0, a_gnt1, a_done0, a_done1, a_we, a_busy});
    end
    total++;
    if ({a_addr, a_data, a_rdata} !== 38'h0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h/%h exp=0", a_addr, a_data, a_rdata);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    preload(6'd5, 16'h00A5);
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd5;
    tick();
    total++;
    if ({a_gnt0, a_gnt1, a_busy, a_addr} !== {3'b101, 6'd5}) begin
      bad++;
      $display("FAIL rd_grant got=%b%b%b addr=%0d exp=101 addr=5",
               a_gnt0, a_gnt1, a_busy, a_addr);
    end
    req0 = 1'b0;
    tick();
    total++;
    if ({a_gnt0, a_we, a_busy} !== 3'b001) begin
      bad++;
      $display("FAIL rd_access got=%b exp=001", {a_gnt0, a_we, a_busy});
    end
    tick();
    total++;
    if (a_done0 !== 1'b1 || a_rdata !== 16'h00A5) begin
      bad++;
      $display("FAIL rd_done got=%b/%h exp=1/00a5", a_done0, a_rdata);
    end
    tick();
    total++;
    if ({a_busy, a_done0} !== 2'b00) begin
      bad++;
      $display("FAIL rd_idle got=%b exp=00", {a_busy, a_done0});
    end
  endtask

  task automatic test_write_read();
    int wecnt = 0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 6'd3; wdata1 = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      tick();
      wecnt += int'(a_we);
      if (i == 0) req1 = 1'b0;
      if (i == 2) begin
        total++;
        if (a_done1 !== 1'b1 || a_rdata !== 16'h00A5) begin
          bad++;
          $display("FAIL wr_done got=%b/%h exp=1/00a5", a_done1, a_rdata);
        end
      end
    end
    total++;
    if (wecnt != 1) begin
      bad++;
      $display("FAIL wr_we_cycles got=%0d exp=1", wecnt);
    end
    req1 = 1'b1; we1 = 1'b0;
    tick();
    req1 = 1'b0;
    tick();
    tick();
    total++;
    if (a_done1 !== 1'b1 || a_rdata !== 16'h1234) begin
      bad++;
      $display("FAIL wr_readback got=%b/%h exp=1/1234", a_done1, a_rdata);
    end
    tick();
  endtask

  task automatic test_contention();
    logic p = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 6'd0; addr1 = 6'd0;
    for (int c = 0; c < 18; c++) begin
      tick();
      total++;
      if (c % 3 == 0) begin
        if ({a_gnt0, a_gnt1} !== {~p, p}) begin
          bad++;
          $display("FAIL rr_grant c=%0d got=%b%b exp=%b%b",
                   c, a_gnt0, a_gnt1, ~p, p);
        end
        p = ~p;
      end else if ({a_gnt0, a_gnt1} !== 2'b00) begin
        bad++;
        $display("FAIL rr_gap c=%0d got=%b%b exp=00", c, a_gnt0, a_gnt1);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_fixed_priority();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    for (int c = 0; c < 18; c++) begin
      tick();
      total++;
      if ({f_gnt0, f_gnt1} !== {(c % 3 == 0), 1'b0}) begin
        bad++;
        $display("FAIL fp_grant c=%0d got=%b%b exp=%b0",
                 c, f_gnt0, f_gnt1, (c % 3 == 0));
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_late_req();
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd5;
    tick();
    total++;
    if (a_gnt0 !== 1'b1) begin
      bad++;
      $display("FAIL late_g0 got=%b exp=1", a_gnt0);
    end
    req0 = 1'b0;
    tick();
    req1 = 1'b1; we1 = 1'b0; addr1 = 6'd5;
    tick();
    total++;
    if ({a_done0, a_gnt1} !== 2'b10) begin
      bad++;
      $display("FAIL late_capture got=%b exp=10", {a_done0, a_gnt1});
    end
    tick();
    total++;
    if ({a_done0, a_gnt1} !== 2'b01) begin
      bad++;
      $display("FAIL late_grant got=%b exp=01", {a_done0, a_gnt1});
    end
    req1 = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    int dn = 0;
    preload(6'd9, 16'h0000);
    req1 = 1'b1; we1 = 1'b1; addr1 = 6'd9; wdata1 = 16'hBEEF;
    tick();
    total++;
    if (a_we !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre_we got=%b exp=1", a_we);
    end
    req1 = 1'b0; we1 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({a_we, a_busy, a_gnt1} !== 3'b000) begin
      bad++;
      $display("FAIL rst_async got=%b exp=000", {a_we, a_busy, a_gnt1});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      dn += int'(a_done0) + int'(a_done1);
    end
    rst_n = 1'b1;
    tick();
    dn += int'(a_done0) + int'(a_done1);
    total++;
    if (dn != 0 || mem_a[9] !== 16'h0000) begin
      bad++;
      $display("FAIL rst_no_done got=%0d/%h exp=0/0000", dn, mem_a[9]);
    end
    req0 = 1'b1; req1 = 1'b1;
    tick();
    total++;
    if ({a_gnt0, a_gnt1} !== 2'b10) begin
      bad++;
      $display("FAIL rst_first_win got=%b exp=10", {a_gnt0, a_gnt1});
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_random();
    logic [15:0] mm [64];
    logic        pend [2];
    logic        rwe [2];
    logic [5:0]  rad [2];
    logic [15:0] rdt [2];
    int          cnt = 0;
    logic        mlast = 1'b1;
    logic        mown = 1'b0;
    logic        mop = 1'b0;
    logic [15:0] mrd = '0;
    logic [15:0] mnext = '0;
    logic [5:0]  eaddr = '0;
    logic [5:0]  ev;
    logic        w;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      mm[i] = 16'($urandom);
      preload(6'(i), mm[i]);
    end
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; rwe[p] = 1'b0; rad[p] = '0; rdt[p] = '0;
    end
    for (int c = 0; c < 500; c++) begin
      req0 = pend[0]; we0 = rwe[0]; addr0 = rad[0]; wdata0 = rdt[0];
      req1 = pend[1]; we1 = rwe[1]; addr1 = rad[1]; wdata1 = rdt[1];
      ev = '0;
      if (cnt == 0) begin
        if (req0 || req1) begin
          if (req0 && req1) w = ~mlast;
          else w = req1;
          ev[5 - int'(w)] = 1'b1;
          ev[1] = rwe[w];
          mown = w;
          mlast = w;
          mop = rwe[w];
          eaddr = rad[w];
          if (rwe[w]) mm[rad[w]] = rdt[w];
          else mnext = mm[rad[w]];
          cnt = 2;
        end
      end else begin
        cnt--;
        if (cnt == 0) begin
          ev[3 - int'(mown)] = 1'b1;
          if (!mop) mrd = mnext;
        end
      end
      ev[0] = (cnt != 0);
      tick();
      total++;
      if ({a_gnt0, a_gnt1, a_done0, a_done1, a_we, a_busy} !== ev ||
          a_rdata !== mrd) begin
        bad++;
        $display("FAIL rand c=%0d got=%b/%h exp=%b/%h", c,
                 {a_gnt0, a_gnt1, a_done0, a_done1, a_we, a_busy},
                 a_rdata, ev, mrd);
      end
      if (ev[5] || ev[4]) begin
        total++;
        if (a_addr !== eaddr) begin
          bad++;
          $display("FAIL rand_addr c=%0d got=%0d exp=%0d", c, a_addr, eaddr);
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (ev[5 - p] || (!pend[p] && ($urandom % 3 == 0))) begin
          pend[p] = (ev[5 - p]) ? 1'($urandom) : 1'b1;
          rwe[p] = 1'($urandom);
          rad[p] = 6'($urandom);
          rdt[p] = 16'($urandom);
        end else if (pend[p] && ($urandom % 8 == 0)) begin
          pend[p] = 1'b0;
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_fixed_priority();
    test_late_req();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
